// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the instruction-cache state encoding.
package cpu_pkg;

    // Boot ROM base; the instruction cache refills from here.
    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    // addi x0, x0, 0 -- returned whenever the cache has no valid word.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REFILL    = 2'd1,
        FILL_DONE = 2'd2
    } icache_state_t;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and backing-memory-side signals of the instruction cache.
// The slave view is the cache itself; the master view is its environment
// (PC / fetch stage plus the backing ROM).
interface icache_dm_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic [31:0]       instr;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  req, addr, flush, mem_rdata, mem_ack,
        output instr, stall, mem_req, mem_addr
    );

    modport master (
        output req, addr, flush, mem_rdata, mem_ack,
        input  instr, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_refill_fsm.sv
// Miss handling for the direct-mapped instruction cache: latches the missing
// line base, walks the line word by word over the req/ack handshake, and
// produces the array write strobes. Only the latched base is used once a
// refill has started, so a wandering fetch address cannot corrupt the fill.
module icache_refill_fsm
    import cpu_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32,
    localparam int BEAT_W = $clog2(WORDS),
    localparam int IDX_W  = $clog2(SETS),
    localparam int OFF    = BEAT_W + 2,
    localparam int LINE_W = ADDR_W - OFF,
    localparam int TAG_W  = LINE_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              hit_i,
    input  logic              flush_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              wr_word_o,
    output logic              wr_line_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [TAG_W-1:0]  wr_tag_o,
    output logic [BEAT_W-1:0] wr_beat_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    icache_state_t     state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] base_q, base_d;

    // State, beat counter and latched line base; reset abandons any fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
        end
    end

    // Next-state and handshake/strobe generation; flush beats a last-beat ack.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        base_d    = base_q;
        mem_req_o = 1'b0;
        wr_word_o = 1'b0;
        wr_line_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i && !hit_i && !flush_i) begin
                    base_d  = line_i;
                    beat_d  = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                mem_req_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (mem_ack_i) begin
                    wr_word_o = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        wr_line_o = 1'b1;
                        beat_d    = '0;
                        state_d   = FILL_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            FILL_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign mem_addr_o = {base_q, beat_q, 2'b00};
    assign wr_idx_o   = base_q[IDX_W-1:0];
    assign wr_tag_o   = base_q[LINE_W-1:IDX_W];
    assign wr_beat_o  = beat_q;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally in
// the lookup cycle; misses stall the PC while icache_refill_fsm pulls the
// line from the backing ROM. Valid/tag/data live in flops.
module icache_dm
    import cpu_pkg::*;
#(
    parameter int SETS   = 16,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    icache_dm_if.slave   bus
);

    localparam int BEAT_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int OFF    = BEAT_W + 2;
    localparam int LINE_W = ADDR_W - OFF;
    localparam int TAG_W  = LINE_W - IDX_W;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS][WORDS];

    logic [BEAT_W-1:0] word_sel;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic              hit;

    logic              busy;
    logic              wr_word;
    logic              wr_line;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic [BEAT_W-1:0] wr_beat;

    // Byte-offset bits are meaningless for word fetches.
    logic unused_byte_bits;
    assign unused_byte_bits = ^bus.addr[1:0];

    assign word_sel = bus.addr[OFF-1:2];
    assign index    = bus.addr[OFF+IDX_W-1:OFF];
    assign tag      = bus.addr[ADDR_W-1:OFF+IDX_W];

    // A lookup coinciding with flush is forced to miss so it never reads a
    // line that is being invalidated.
    assign hit = bus.req && !bus.flush && valid_q[index] && (tag_q[index] == tag);

    assign bus.instr = hit ? data_q[index][word_sel] : NOP_INSTR;
    assign bus.stall = busy ? 1'b1 : (bus.req && !hit);

    icache_refill_fsm #(
        .SETS   (SETS),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) u_refill (
        .clk        (clk),
        .rst        (rst),
        .req_i      (bus.req),
        .hit_i      (hit),
        .flush_i    (bus.flush),
        .line_i     (bus.addr[ADDR_W-1:OFF]),
        .mem_ack_i  (bus.mem_ack),
        .busy_o     (busy),
        .mem_req_o  (bus.mem_req),
        .mem_addr_o (bus.mem_addr),
        .wr_word_o  (wr_word),
        .wr_line_o  (wr_line),
        .wr_idx_o   (wr_idx),
        .wr_tag_o   (wr_tag),
        .wr_beat_o  (wr_beat)
    );

    // Valid bits: cleared by reset or flush, set only once the whole line is in.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid_q <= '0;
        end else if (wr_line) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_line
            // Tag is written together with the valid bit on the final beat.
            always_ff @(posedge clk) begin
                if (wr_line && (wr_idx == IDX_W'(gi))) begin
                    tag_q[gi] <= wr_tag;
                end
            end

            // One data word per accepted beat; an aborted beat is dropped.
            always_ff @(posedge clk) begin
                if (wr_word && (wr_idx == IDX_W'(gi))) begin
                    data_q[gi][wr_beat] <= bus.mem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold miss, hit sweep, conflict, slow ROM,
// flush during refill and reset during refill.
module tb_icache_dm;
    import cpu_pkg::*;

    logic clk;
    logic rst;

    icache_dm_if #(.ADDR_W(32)) bus ();

    icache_dm #(
        .SETS   (16),
        .WORDS  (4),
        .ADDR_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ROM model: word at RESET_VECTOR + 4*k holds 0x1000 + k.
    int ack_delay = 0;
    int wait_cnt  = 0;
    assign bus.mem_ack   = bus.mem_req && (wait_cnt == ack_delay);
    assign bus.mem_rdata = 32'h1000 + ((bus.mem_addr - RESET_VECTOR) >> 2);

    always @(posedge clk) begin
        if (rst || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else                                    wait_cnt <= wait_cnt + 1;
    end

    logic [31:0] beat_addr[$];
    logic        addr_stable;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold req on address a until stall drops; leaves the hitting cycle active.
    task automatic fetch(input logic [31:0] a, output int stalls);
        int          guard;
        logic [31:0] prev;
        logic        waiting;
        stalls      = 0;
        guard       = 0;
        waiting     = 1'b0;
        prev        = '0;
        addr_stable = 1'b1;
        beat_addr.delete();
        do begin
            @(negedge clk);
            bus.req  = 1'b1;
            bus.addr = a;
            #1;
            if (bus.mem_req) begin
                if (waiting && (bus.mem_addr !== prev)) addr_stable = 1'b0;
                if (bus.mem_ack) begin
                    beat_addr.push_back(bus.mem_addr);
                    waiting = 1'b0;
                end else begin
                    waiting = 1'b1;
                    prev    = bus.mem_addr;
                end
            end else begin
                waiting = 1'b0;
            end
            if (bus.stall) stalls++;
            guard++;
        end while (bus.stall && guard < 200);
        if (guard >= 200) check("fetch_timeout", 32'(guard), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stalls;
        int          acks;
        int          g;
        logic [31:0] sweep_a [3];
        logic [31:0] sweep_d [3];

        rst       = 1'b1;
        bus.req   = 1'b0;
        bus.addr  = '0;
        bus.flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall",   32'(bus.stall),   32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_instr",   bus.instr,        NOP_INSTR);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_instr", bus.instr, NOP_INSTR);

        // Cold miss at the reset vector
        fetch(32'hBFC00000, stalls);
        check("cold_stalls", 32'(stalls), 32'd6);
        check("cold_beats",  32'(beat_addr.size()), 32'd4);
        check("cold_addr0",  beat_addr[0], 32'hBFC00000);
        check("cold_addr1",  beat_addr[1], 32'hBFC00004);
        check("cold_addr2",  beat_addr[2], 32'hBFC00008);
        check("cold_addr3",  beat_addr[3], 32'hBFC0000C);
        check("cold_instr",  bus.instr,    32'h00001000);

        // Hit sweep across the rest of the line
        sweep_a = '{32'hBFC00004, 32'hBFC00008, 32'hBFC0000C};
        sweep_d = '{32'h00001001, 32'h00001002, 32'h00001003};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.addr = sweep_a[i];
            #1;
            check("hit_instr",   bus.instr,        sweep_d[i]);
            check("hit_stall",   32'(bus.stall),   32'd0);
            check("hit_mem_req", 32'(bus.mem_req), 32'd0);
        end

        // Conflict: same index 0, different tag, then back again
        fetch(32'hBFC00100, stalls);
        check("conf_stalls", 32'(stalls), 32'd6);
        check("conf_addr0",  beat_addr[0], 32'hBFC00100);
        check("conf_addr3",  beat_addr[3], 32'hBFC0010C);
        check("conf_instr",  bus.instr,    32'h00001040);
        fetch(32'hBFC00000, stalls);
        check("conf_remiss", 32'(stalls), 32'd6);
        check("conf_reinstr", bus.instr, 32'h00001000);

        // Slow ROM: three wait cycles before each ack
        ack_delay = 3;
        fetch(32'hBFC00010, stalls);
        check("slow_stalls", 32'(stalls), 32'd18);
        check("slow_beats",  32'(beat_addr.size()), 32'd4);
        check("slow_stable", 32'(addr_stable), 32'd1);
        check("slow_instr",  bus.instr, 32'h00001004);
        @(negedge clk);
        bus.addr = 32'hBFC0001C;
        #1;
        check("slow_hit", bus.instr, 32'h00001007);
        ack_delay = 0;

        // Flush after the second ack of a refill
        acks = 0;
        g    = 0;
        while (acks < 2 && g < 50) begin
            @(negedge clk);
            bus.req  = 1'b1;
            bus.addr = 32'hBFC00020;
            #1;
            if (bus.mem_ack) acks++;
            g++;
        end
        check("flush_acks", 32'(acks), 32'd2);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.req   = 1'b0;
        #1;
        check("flush_mem_req", 32'(bus.mem_req), 32'd0);
        check("flush_idle",    32'(bus.stall),   32'd0);
        fetch(32'hBFC00020, stalls);
        check("flush_stalls", 32'(stalls), 32'd6);
        check("flush_beats",  32'(beat_addr.size()), 32'd4);
        check("flush_addr0",  beat_addr[0], 32'hBFC00020);
        check("flush_instr",  bus.instr, 32'h00001008);
        fetch(32'hBFC00000, stalls);
        check("flush_inval0", 32'(stalls), 32'd6);

        // Reset after the first ack of a refill
        acks = 0;
        g    = 0;
        while (acks < 1 && g < 50) begin
            @(negedge clk);
            bus.req  = 1'b1;
            bus.addr = 32'hBFC00030;
            #1;
            if (bus.mem_ack) acks++;
            g++;
        end
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_mem_req", 32'(bus.mem_req), 32'd0);
        check("mrst_stall",   32'(bus.stall),   32'd0);
        check("mrst_instr",   bus.instr,        NOP_INSTR);
        fetch(32'hBFC00030, stalls);
        check("mrst_stalls", 32'(stalls), 32'd6);
        check("mrst_beats",  32'(beat_addr.size()), 32'd4);
        check("mrst_instr2", bus.instr, 32'h0000100C);
        fetch(32'hBFC00020, stalls);
        check("mrst_inval", 32'(stalls), 32'd6);

        @(negedge clk);
        bus.req = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
